// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a one-cold column drive, debounces the
// synchronized rows, and emits a key position with a one-cycle write strobe.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fila,
    output logic [3:0] col,
    output logic [3:0] posicion,
    output logic       opr,
    output logic       key_held
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] prescaler;
    logic          tick;
    logic [3:0]    sync1, rs;
    logic [CW-1:0] count, count_n, cnt_inc;
    logic [1:0]    cand_row, cand_row_n;
    logic [1:0]    cand_col, cand_col_n;
    logic [3:0]    col_n, col_rot, posicion_n;
    logic          opr_n, key_held_n;
    logic [3:0]    row_low, cand_pattern;
    logic          row_single;
    logic [1:0]    row_idx, col_idx;

    // Rows are asynchronous to clk; reset to 1111 so the scanner starts idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 4'b1111;
            rs    <= 4'b1111;
        end else begin
            sync1 <= fila;
            rs    <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign tick = (prescaler == PRE_MAX);

    // Exactly one row pulled low; two or more means ghosting or multi-key.
    assign row_low    = ~rs;
    assign row_single = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);

    always_comb begin
        row_idx = 2'd0;
        case (rs)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    always_comb begin
        col_idx = 2'd0;
        case (col)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    assign col_rot      = {col[2:0], col[3]};
    assign cand_pattern = ~(4'b0001 << cand_row);
    assign cnt_inc      = count + CNT_ONE;

    // NOTE: every next-state value gets its hold default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_n    = state;
        col_n      = col;
        count_n    = count;
        cand_row_n = cand_row;
        cand_col_n = cand_col;
        posicion_n = posicion;
        opr_n      = 1'b0;
        key_held_n = key_held;

        case (state)
            SCAN: begin
                if (tick) begin
                    if (row_single) begin
                        cand_row_n = row_idx;
                        cand_col_n = col_idx;
                        if (CNT_ONE == CNT_DONE) begin
                            posicion_n = {row_idx, col_idx};
                            opr_n      = 1'b1;
                            key_held_n = 1'b1;
                            count_n    = '0;
                            state_n    = HELD;
                        end else begin
                            count_n = CNT_ONE;
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        col_n = col_rot;
                    end
                end
            end

            DEBOUNCE: begin
                if (tick) begin
                    if (rs == cand_pattern) begin
                        if (cnt_inc == CNT_DONE) begin
                            // {row, col} is exactly 4*row + col.
                            posicion_n = {cand_row, cand_col};
                            opr_n      = 1'b1;
                            key_held_n = 1'b1;
                            count_n    = '0;
                            state_n    = HELD;
                        end else begin
                            count_n = cnt_inc;
                        end
                    end else begin
                        count_n = '0;
                        col_n   = col_rot;
                        state_n = SCAN;
                    end
                end
            end

            HELD: begin
                if (tick) begin
                    if (rs == 4'b1111) begin
                        if (cnt_inc == CNT_DONE) begin
                            key_held_n = 1'b0;
                            count_n    = '0;
                            col_n      = col_rot;
                            state_n    = SCAN;
                        end else begin
                            count_n = cnt_inc;
                        end
                    end else begin
                        count_n = '0;
                    end
                end
            end

            default: begin
                state_n = SCAN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SCAN;
            col      <= 4'b1110;
            count    <= '0;
            cand_row <= 2'd0;
            cand_col <= 2'd0;
            posicion <= 4'd0;
            opr      <= 1'b0;
            key_held <= 1'b0;
        end else begin
            state    <= state_n;
            col      <= col_n;
            count    <= count_n;
            cand_row <= cand_row_n;
            cand_col <= cand_col_n;
            posicion <= posicion_n;
            opr      <= opr_n;
            key_held <= key_held_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives fila from col, and a
// scoreboard queue of expected positions is checked on every opr pulse.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fila;
    logic [3:0] col;
    logic [3:0] posicion;
    logic       opr;
    logic       key_held;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_TICKS(DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .fila    (fila),
        .col     (col),
        .posicion(posicion),
        .opr     (opr),
        .key_held(key_held)
    );

    // Keypad model: a pressed key pulls its row low only while its column is driven low.
    logic       key_on;
    logic [1:0] key_r, key_c;
    logic       use_force;
    logic [3:0] force_val;

    always_comb begin
        fila = 4'b1111;
        if (use_force) begin
            fila = force_val;
        end else if (key_on && (col[key_c] == 1'b0)) begin
            fila[key_r] = 1'b0;
        end
    end

    int         total     = 0;
    int         bad       = 0;
    int         opr_seen  = 0;
    logic       prev_opr  = 1'b0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every opr pulse must match the oldest expected position.
    always @(negedge clk) begin
        if (opr === 1'b1) begin
            opr_seen++;
            check("opr_not_back_to_back", {31'd0, prev_opr}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_opr: got posicion %0d with nothing expected", posicion);
            end else begin
                check("posicion_at_opr", {28'd0, posicion}, {28'd0, exp_q.pop_front()});
            end
        end
        prev_opr = opr;
    end

    function automatic logic [3:0] sig_val(input int which);
        case (which)
            0:       return {3'b000, opr};
            1:       return {3'b000, key_held};
            default: return col;
        endcase
    endfunction

    // Waits (bounded) for a DUT output to reach val; returns on that negedge.
    task automatic wait_sig(input int which, input logic [3:0] val, input int max_cyc,
                            input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (sig_val(which) !== val && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, {28'd0, sig_val(which)}, {28'd0, val});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rot [4];
        logic [3:0] prev_col;
        int         base;
        int         rots;

        rot = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        rst       = 1'b1;
        key_on    = 1'b0;
        key_r     = 2'd0;
        key_c     = 2'd0;
        use_force = 1'b1;
        force_val = 4'b0000;

        // Reset with all rows low.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_col", {28'd0, col}, 32'b1110);
        check("reset_posicion", {28'd0, posicion}, 32'd0);
        check("reset_opr", {31'd0, opr}, 32'd0);
        check("reset_key_held", {31'd0, key_held}, 32'd0);

        // Idle rotation every SCAN_DIV cycles.
        @(posedge clk);
        #1;
        rst       = 1'b0;
        use_force = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("rotate_cycle_%0d", i), {28'd0, col}, {28'd0, rot[(i / 4) % 4]});
        end

        // Clean press at row 2 / col 1.
        base = opr_seen;
        exp_q.push_back(4'd9);
        key_r  = 2'd2;
        key_c  = 2'd1;
        key_on = 1'b1;
        wait_sig(0, 4'd1, 100, "clean_opr_seen");
        check("clean_key_held", {31'd0, key_held}, 32'd1);
        check("clean_col_frozen", {28'd0, col}, 32'b1101);
        repeat (40) @(negedge clk);
        check("clean_still_frozen", {28'd0, col}, 32'b1101);
        check("clean_still_held", {31'd0, key_held}, 32'd1);
        check("clean_single_opr", opr_seen, base + 1);
        key_on = 1'b0;
        repeat (8) @(negedge clk);
        check("release_not_early", {31'd0, key_held}, 32'd1);
        wait_sig(1, 4'd0, 60, "release_held_drop");
        check("release_rotates", {28'd0, col}, 32'b1011);

        // Bounce: one matching tick, then idle.
        base = opr_seen;
        wait_sig(2, 4'b1101, 100, "bounce_reach_col");
        key_on = 1'b1;
        repeat (4) @(negedge clk);
        key_on = 1'b0;
        @(negedge clk);
        check("bounce_col_frozen", {28'd0, col}, 32'b1101);
        repeat (3) @(negedge clk);
        check("bounce_rotates", {28'd0, col}, 32'b1011);
        check("bounce_not_held", {31'd0, key_held}, 32'd0);
        check("bounce_pos_kept", {28'd0, posicion}, 32'd9);
        check("bounce_no_opr", opr_seen, base);

        // Long hold at row 0 / col 3, then release with a one-tick glitch.
        base = opr_seen;
        exp_q.push_back(4'd3);
        key_r  = 2'd0;
        key_c  = 2'd3;
        key_on = 1'b1;
        wait_sig(0, 4'd1, 100, "hold_opr_seen");
        repeat (200) @(negedge clk);
        check("hold_key_held", {31'd0, key_held}, 32'd1);
        check("hold_single_opr", opr_seen, base + 1);
        check("hold_posicion", {28'd0, posicion}, 32'd3);
        key_on = 1'b0;
        repeat (8) @(negedge clk);
        key_on = 1'b1;
        repeat (4) @(negedge clk);
        key_on = 1'b0;
        repeat (8) @(negedge clk);
        check("glitch_restarts_count", {31'd0, key_held}, 32'd1);
        repeat (3) @(negedge clk);
        check("glitch_held_before_third", {31'd0, key_held}, 32'd1);
        @(negedge clk);
        check("glitch_release_done", {31'd0, key_held}, 32'd0);
        check("glitch_release_rotates", {28'd0, col}, 32'b1110);

        // Ghosting pattern is never a candidate.
        base      = opr_seen;
        use_force = 1'b1;
        force_val = 4'b1010;
        prev_col  = col;
        rots      = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (col != prev_col) rots++;
            prev_col = col;
        end
        use_force = 1'b0;
        check("ghost_rotations", rots, 32'd8);
        check("ghost_no_opr", opr_seen, base);
        check("ghost_not_held", {31'd0, key_held}, 32'd0);

        // Reset in the opr cycle; the held key is then detected afresh.
        exp_q.push_back(4'd6);
        key_r  = 2'd1;
        key_c  = 2'd2;
        key_on = 1'b1;
        wait_sig(0, 4'd1, 100, "pre_reset_opr_seen");
        rst = 1'b1;
        exp_q.push_back(4'd6);
        @(negedge clk);
        check("midreset_col", {28'd0, col}, 32'b1110);
        check("midreset_posicion", {28'd0, posicion}, 32'd0);
        check("midreset_opr", {31'd0, opr}, 32'd0);
        check("midreset_key_held", {31'd0, key_held}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_sig(0, 4'd1, 100, "second_opr_seen");
        check("second_opr_posicion", {28'd0, posicion}, 32'd6);
        key_on = 1'b0;
        wait_sig(1, 4'd0, 60, "final_release");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("opr_total", opr_seen, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
